residual_readout: RTL and testbench

- Reader side of the residual store filled by the pipeline writeback stage. After a start pulse, sweeps every POI, reads the 32 window rows of 8-bit residuals per POI, and finds the minimum residual and its (row, col) offset.
- Emits one best-match record per POI over a valid/ready handshake to the downstream stitching/transform logic, then pulses done.

---
 rtl/residual_readout.sv | 194 +++++++++++++++++++
 tb/tb_residual_readout.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/residual_readout.sv
// Residual store reader: sweeps every POI, reads its 32 window rows of
// 8-bit residuals, finds the minimum residual and its (row, col) offset and
// hands one best-match record per POI downstream.
//
// Output handshake: a record is transferred on a cycle where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low all
// out_* fields hold steady, and out_valid never drops without a transfer.
module residual_readout #(
    parameter int POI_DEPTH = 4,
    parameter int POI_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    output logic                           busy,
    output logic                           rd_en,
    output logic [POI_DEPTH+POI_WIDTH+4:0] rd_addr,
    input  logic [255:0]                   rd_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [POI_DEPTH+POI_WIDTH-1:0] out_poi,
    output logic [4:0]                     out_row,
    output logic [4:0]                     out_col,
    output logic [7:0]                     out_val,
    output logic                           done
);

    localparam int PW = POI_DEPTH + POI_WIDTH;
    localparam int TOTAL_POI = 1 << PW;
    localparam logic [PW-1:0] LAST_POI = PW'(TOTAL_POI - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_OUT,
        S_FIN
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [PW-1:0]   poi_q;
    logic [4:0]      row_q;

    // Read-data pipeline tag: which row the current rd_data belongs to.
    logic            data_vld_q;
    logic [4:0]      data_row_q;

    // Running minimum over the rows seen so far for the current POI.
    logic [7:0]      run_val_q;
    logic [4:0]      run_row_q;
    logic [4:0]      run_col_q;

    // Per-row reduction and merged candidate.
    logic [7:0]      row_min;
    logic [4:0]      row_mincol;
    logic [7:0]      cand_val;
    logic [4:0]      cand_row;
    logic [4:0]      cand_col;

    logic            min_restart;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed 32-cycle read burst, one drain cycle, then
    // hold the record until it is taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_READ;
            S_READ:  if (row_q == 5'd31) state_d = S_DRAIN;
            S_DRAIN: state_d = S_OUT;
            S_OUT: begin
                if (out_ready) begin
                    state_d = (poi_q == LAST_POI) ? S_FIN : S_READ;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control outputs decoded straight from the state.
    always_comb begin
        rd_en     = (state_q == S_READ);
        rd_addr   = {poi_q, row_q};
        out_valid = (state_q == S_OUT);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_FIN);
    end

    // POI and window-row counters; row wraps to 0 naturally after row 31.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            poi_q <= '0;
            row_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        poi_q <= '0;
                        row_q <= '0;
                    end
                end
                S_READ: row_q <= row_q + 5'd1;
                S_OUT: begin
                    if (out_ready && (poi_q != LAST_POI)) begin
                        poi_q <= poi_q + 1'b1;
                        row_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Delay the read strobe and row tag to line up with the returning data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_vld_q <= 1'b0;
            data_row_q <= '0;
        end else begin
            data_vld_q <= rd_en;
            data_row_q <= row_q;
        end
    end

    // Row reduction: strict less-than scan so the lowest column wins ties.
    always_comb begin
        row_min    = rd_data[7:0];
        row_mincol = '0;
        for (int c = 1; c < 32; c++) begin
            if (rd_data[8*c +: 8] < row_min) begin
                row_min    = rd_data[8*c +: 8];
                row_mincol = 5'(c);
            end
        end
    end

    // Merge the row result into the running minimum; earlier rows win ties.
    always_comb begin
        cand_val = run_val_q;
        cand_row = run_row_q;
        cand_col = run_col_q;
        if (data_vld_q && (row_min < run_val_q)) begin
            cand_val = row_min;
            cand_row = data_row_q;
            cand_col = row_mincol;
        end
    end

    assign min_restart = ((state_q == S_IDLE) && start) ||
                         ((state_q == S_OUT) && out_ready);

    // Running-minimum registers, cleared at the start of every POI.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_val_q <= 8'hFF;
            run_row_q <= '0;
            run_col_q <= '0;
        end else if (min_restart) begin
            run_val_q <= 8'hFF;
            run_row_q <= '0;
            run_col_q <= '0;
        end else if (data_vld_q) begin
            run_val_q <= cand_val;
            run_row_q <= cand_row;
            run_col_q <= cand_col;
        end
    end

    // Record register, loaded in the drain cycle so row 31 is included.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_poi <= '0;
            out_row <= '0;
            out_col <= '0;
            out_val <= 8'hFF;
        end else if (state_q == S_DRAIN) begin
            out_poi <= poi_q;
            out_row <= cand_row;
            out_col <= cand_col;
            out_val <= cand_val;
        end
    end

endmodule

// File: tb/tb_residual_readout.sv
// Directed bench for residual_readout: reset behaviour, full POI sweeps
// against a residual memory model, ties, boundary rows/cols, backpressure
// and the done pulse.
module tb_residual_readout;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         busy;
    logic         rd_en;
    logic [12:0]  rd_addr;
    logic [255:0] rd_data;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_poi;
    logic [4:0]   out_row;
    logic [4:0]   out_col;
    logic [7:0]   out_val;
    logic         done;

    int total = 0;
    int bad = 0;
    int mem_mode = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    residual_readout #(.POI_DEPTH(4), .POI_WIDTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_poi   (out_poi),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_val   (out_val),
        .done      (done)
    );

    // Residual contents: mode 0 is the directed pattern, mode 1 all 8'hFF.
    function automatic logic [7:0] mem_byte(input int mode, input int poi,
                                            input int row, input int col);
        if (mode == 1) return 8'hFF;
        if (poi == 5 && row == 17 && col == 9) return 8'h03;
        if (poi == 0 && ((row == 4 && (col == 20 || col == 7)) ||
                         (row == 9 && col == 1))) return 8'h02;
        if (poi == 7 && row == 31 && col == 31) return 8'h10;
        if (poi == 9 && ((row == 0 && col == 31) ||
                         (row == 31 && col == 0))) return 8'h01;
        return 8'h80;
    endfunction

    // Hand-derived best-match record for each POI.
    task automatic exp_rec(input int mode, input int poi, output int r,
                           output int c, output int v);
        r = 0; c = 0; v = 8'h80;
        if (mode == 1) v = 8'hFF;
        else if (poi == 0) begin r = 4;  c = 7;  v = 2;     end
        else if (poi == 5) begin r = 17; c = 9;  v = 3;     end
        else if (poi == 7) begin r = 31; c = 31; v = 8'h10; end
        else if (poi == 9) begin r = 0;  c = 31; v = 1;     end
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: one-cycle read latency, garbage when not read.
    always @(posedge clk) begin : mem_model
        logic [255:0] word;
        if (rd_en) begin
            for (int c = 0; c < 32; c++)
                word[8*c +: 8] = mem_byte(mem_mode, int'(rd_addr[12:5]),
                                          int'(rd_addr[4:0]), c);
        end else begin
            word = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
        end
        rd_data <= word;
    end

    always @(negedge clk) if (done) done_cnt++;

    task automatic run_sweep(input int mode);
        int cyc, rdc, er, ec, ev;
        bit seen;
        mem_mode = mode;
        out_ready = 1'b1;
        done_cnt = 0;
        @(negedge clk) start = 1'b1;
        for (int p = 0; p < 256; p++) begin
            cyc = 0; rdc = 0; seen = 1'b0;
            while (!seen && cyc < 100) begin
                @(negedge clk);
                cyc++;
                if (cyc == 1) start = 1'b0;
                if (p == 2 && cyc == 1) out_ready = 1'b0;
                if (p == 1 && cyc == 5) start = 1'b1;
                if (p == 1 && cyc == 6) start = 1'b0;
                if (rd_en) begin
                    check("rd_addr", 32'(rd_addr), 32'({p[7:0], rdc[4:0]}));
                    rdc++;
                end
                if (out_valid) seen = 1'b1;
            end
            check("out_valid_seen", 32'(seen), 32'd1);
            if (!seen) return;
            check("latency", cyc, 34);
            check("rd_en_cycles", rdc, 32);
            exp_rec(mode, p, er, ec, ev);
            check("out_poi", 32'(out_poi), p);
            check("out_row", 32'(out_row), er);
            check("out_col", 32'(out_col), ec);
            check("out_val", 32'(out_val), ev);
            check("busy_in_out", 32'(busy), 32'd1);
            check("done_early", 32'(done), 32'd0);
            if (p == 2) begin
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    check("bp_valid", 32'(out_valid), 32'd1);
                    check("bp_rd_en", 32'(rd_en), 32'd0);
                    check("bp_poi", 32'(out_poi), 32'd2);
                    check("bp_row", 32'(out_row), er);
                    check("bp_col", 32'(out_col), ec);
                    check("bp_val", 32'(out_val), ev);
                end
                out_ready = 1'b1;
            end
        end
        @(negedge clk);
        check("fin_done", 32'(done), 32'd1);
        check("fin_busy", 32'(busy), 32'd1);
        check("fin_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("done_pulses", done_cnt, 1);
    endtask

    initial begin
        int n;
        bit found;
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(rd_addr), 32'd0);
        check("rst_poi", 32'(out_poi), 32'd0);
        check("rst_row", 32'(out_row), 32'd0);
        check("rst_col", 32'(out_col), 32'd0);
        check("rst_val", 32'(out_val), 32'hFF);
        reset = 1'b0;

        // Reset in the middle of POI 3, row 10.
        mem_mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0; found = 1'b0;
        while (!found && n < 500) begin
            @(negedge clk);
            n++;
            if (rd_en && rd_addr == {8'd3, 5'd10}) found = 1'b1;
        end
        check("reach_poi3_row10", 32'(found), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_rd_en", 32'(rd_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_addr", 32'(rd_addr), 32'd0);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);

        run_sweep(0);
        run_sweep(1);
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
